present_iter_core: RTL and testbench



---
 rtl/present_pkg.sv | 90 +++++++++
 rtl/present_iter_core_if.sv | 32 +++
 rtl/present_round.sv | 12 +
 rtl/present_iter_core.sv | 162 ++++++++++++++++
 tb/tb_present_iter_core.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// PRESENT-64 shared definitions.
// Holds the 4-bit S-box and its inverse, the bit permutation and its inverse,
// the forward and inverse key-schedule updates for 80- and 128-bit keys, and
// the FSM state encoding used by present_iter_core.
package present_pkg;

   // Nibble x of each table sits at bits [4x+3:4x].
   localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
   localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ROUND    = 2'd1,
      ST_DONE     = 2'd2,
      ST_KEYSCHED = 2'd3
   } state_t;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      return SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
      return INV_SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [63:0] sbox_layer(input logic [63:0] d);
      logic [63:0] o;
      for (int i = 0; i < 16; i++) o[4*i +: 4] = sbox4(d[4*i +: 4]);
      return o;
   endfunction

   function automatic logic [63:0] inv_sbox_layer(input logic [63:0] d);
      logic [63:0] o;
      for (int i = 0; i < 16; i++) o[4*i +: 4] = inv_sbox4(d[4*i +: 4]);
      return o;
   endfunction

   // Bit i moves to (16*i) mod 63; bit 63 is a fixed point.
   function automatic logic [63:0] p_layer(input logic [63:0] d);
      logic [63:0] o;
      o[63] = d[63];
      for (int i = 0; i < 63; i++) o[(16*i) % 63] = d[i];
      return o;
   endfunction

   function automatic logic [63:0] inv_p_layer(input logic [63:0] d);
      logic [63:0] o;
      o[63] = d[63];
      for (int i = 0; i < 63; i++) o[i] = d[(16*i) % 63];
      return o;
   endfunction

   // Rotate left 61, S-box the top nibble, fold the round counter in.
   function automatic logic [79:0] key_upd80(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] t;
      t          = {k[18:0], k[79:19]};
      t[79:76]   = sbox4(t[79:76]);
      t[19:15]   = t[19:15] ^ rc;
      return t;
   endfunction

   function automatic logic [127:0] key_upd128(input logic [127:0] k, input logic [4:0] rc);
      logic [127:0] t;
      t          = {k[66:0], k[127:67]};
      t[127:124] = sbox4(t[127:124]);
      t[123:120] = sbox4(t[123:120]);
      t[66:62]   = t[66:62] ^ rc;
      return t;
   endfunction

   // Exact inverses of the two updates above: undo the XOR, undo the S-box,
   // then rotate right 61.
   function automatic logic [79:0] inv_key_upd80(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] t;
      t          = k;
      t[19:15]   = t[19:15] ^ rc;
      t[79:76]   = inv_sbox4(t[79:76]);
      return {t[60:0], t[79:61]};
   endfunction

   function automatic logic [127:0] inv_key_upd128(input logic [127:0] k, input logic [4:0] rc);
      logic [127:0] t;
      t          = k;
      t[66:62]   = t[66:62] ^ rc;
      t[127:124] = inv_sbox4(t[127:124]);
      t[123:120] = inv_sbox4(t[123:120]);
      return {t[60:0], t[127:61]};
   endfunction

endpackage

// File: rtl/present_iter_core_if.sv
// Streaming handshake bundle for present_iter_core.
// master: upstream/downstream side (drives in_valid, plaintext, key,
//         out_ready and, with PRESENT_DECRYPT_EN, dec).
// slave : the core (drives in_ready, out_valid, ciphertext).
interface present_iter_core_if #(parameter int KEY_W = 80);
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      plaintext;
   logic [KEY_W-1:0] key;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      ciphertext;
`ifdef PRESENT_DECRYPT_EN
   logic             dec;
`endif

   modport master (
`ifdef PRESENT_DECRYPT_EN
      output dec,
`endif
      output in_valid, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext
   );

   modport slave (
`ifdef PRESENT_DECRYPT_EN
      input  dec,
`endif
      input  in_valid, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext
   );
endinterface

// File: rtl/present_round.sv
// One PRESENT encryption round, purely combinational:
//   nxt = pLayer(sBoxLayer(st ^ rk))
// Ports: st (64, state in), rk (64, round key), nxt (64, next state).
import present_pkg::*;

module present_round (
   input  logic [63:0] st,
   input  logic [63:0] rk,
   output logic [63:0] nxt
);
   assign nxt = p_layer(sbox_layer(st ^ rk));
endmodule

// File: rtl/present_iter_core.sv
// Iterative PRESENT-64 core: one round per clock, key schedule on the fly.
// Encrypt: accept -> NUM_ROUNDS ROUND cycles -> DONE (out_valid held until
// out_ready). Optional decrypt (macro PRESENT_DECRYPT_EN): KEYSCHED runs the
// forward schedule to K_{N+1} plus one whitening cycle, then NUM_ROUNDS
// inverse rounds walk the key schedule backwards.
// Ports: clk, rst_n (async active-low), bus (present_iter_core_if.slave:
//   in_valid/in_ready/plaintext/key[/dec], out_valid/out_ready/ciphertext).
import present_pkg::*;

module present_iter_core #(
   parameter int KEY_W      = 80,
   parameter int NUM_ROUNDS = 31
) (
   input logic                clk,
   input logic                rst_n,
   present_iter_core_if.slave bus
);
   localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

   if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
      $error("present_iter_core: KEY_W must be 80 or 128");
   end
   if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_rounds
      $error("present_iter_core: NUM_ROUNDS must be in 1..31");
   end

   state_t           state;
   logic [63:0]      st;
   logic [KEY_W-1:0] kreg;
   logic [4:0]       rc;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [63:0]      ct_q;

   logic [KEY_W-1:0] k_fwd;
   logic [63:0]      rk;
   logic [63:0]      round_out;

   assign rk = kreg[KEY_W-1 -: 64];

   present_round u_round (
      .st  (st),
      .rk  (rk),
      .nxt (round_out)
   );

`ifdef PRESENT_DECRYPT_EN
   logic             dec_q;
   logic [KEY_W-1:0] k_inv;
   logic [63:0]      inv_out;
`endif

   if (KEY_W == 128) begin : g_k128
      assign k_fwd = key_upd128(kreg, rc);
`ifdef PRESENT_DECRYPT_EN
      assign k_inv = inv_key_upd128(kreg, rc);
`endif
   end else begin : g_k80
      assign k_fwd = key_upd80(kreg, rc);
`ifdef PRESENT_DECRYPT_EN
      assign k_inv = inv_key_upd80(kreg, rc);
`endif
   end

`ifdef PRESENT_DECRYPT_EN
   // Inverse round uses K_rc, recovered from K_{rc+1} held in kreg.
   assign inv_out = inv_sbox_layer(inv_p_layer(st)) ^ k_inv[KEY_W-1 -: 64];
`endif

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.ciphertext = ct_q;

   // NOTE: state registers use non-blocking assignments so every branch sees
   // the pre-edge values of st/kreg/rc, matching the combinational round logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         ct_q        <= '0;
         rc          <= '0;
         // NOTE: st/kreg are overwritten on every accept, so their reset is
         // only for a clean, X-free state after an abort.
         st          <= '0;
         kreg        <= '0;
`ifdef PRESENT_DECRYPT_EN
         dec_q       <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  st         <= bus.plaintext;
                  kreg       <= bus.key;
                  rc         <= 5'd1;
                  in_ready_q <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
                  dec_q      <= bus.dec;
                  state      <= bus.dec ? ST_KEYSCHED : ST_ROUND;
`else
                  state      <= ST_ROUND;
`endif
               end else begin
                  in_ready_q <= 1'b1;
               end
            end

`ifdef PRESENT_DECRYPT_EN
            // rc=1..N: forward key updates; rc wraps to 0 for one whitening
            // cycle, then the inverse rounds start at rc=N.
            ST_KEYSCHED: begin
               if (rc == 5'd0) begin
                  st    <= st ^ rk;
                  rc    <= LAST;
                  state <= ST_ROUND;
               end else begin
                  kreg <= k_fwd;
                  rc   <= (rc == LAST) ? 5'd0 : rc + 5'd1;
               end
            end
`endif

            ST_ROUND: begin
`ifdef PRESENT_DECRYPT_EN
               if (dec_q) begin
                  st   <= inv_out;
                  kreg <= k_inv;
                  rc   <= rc - 5'd1;
                  if (rc == 5'd1) begin
                     ct_q        <= inv_out;
                     out_valid_q <= 1'b1;
                     state       <= ST_DONE;
                  end
               end else
`endif
               begin
                  st   <= round_out;
                  kreg <= k_fwd;
                  rc   <= rc + 5'd1;
                  if (rc == LAST) begin
                     // Final whitening with K_{N+1}.
                     ct_q        <= round_out ^ k_fwd[KEY_W-1 -: 64];
                     out_valid_q <= 1'b1;
                     state       <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_present_iter_core.sv
// Self-checking bench for present_iter_core: published 80/128-bit vectors,
// latency, backpressure, reset abort and (with PRESENT_DECRYPT_EN) decrypt.
module tb_present_iter_core;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   present_iter_core_if #(.KEY_W(80))  b80 ();
   present_iter_core_if #(.KEY_W(128)) b128 ();

   present_iter_core #(.KEY_W(80), .NUM_ROUNDS(31)) dut80 (
      .clk(clk), .rst_n(rst_n), .bus(b80));
   present_iter_core #(.KEY_W(128), .NUM_ROUNDS(31)) dut128 (
      .clk(clk), .rst_n(rst_n), .bus(b128));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [63:0] pt;
      logic [79:0] key;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one block on the 80-bit core and wait for the result.
   task automatic run80(input logic [63:0] pt, input logic [79:0] key, input logic dec,
                        output logic [63:0] ct, output int lat);
      int guard;
      guard = 0;
      while (!b80.in_ready && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 200) check("run80_in_ready_timeout", 64'(guard), 64'd0);
      b80.plaintext = pt;
      b80.key       = key;
`ifdef PRESENT_DECRYPT_EN
      b80.dec       = dec;
`else
      if (dec) $display("note: decrypt requested on an encrypt-only build");
`endif
      b80.in_valid  = 1'b1;
      @(posedge clk); #1;
      b80.in_valid  = 1'b0;
      lat = 0;
      while (!b80.out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      ct = b80.ciphertext;
      @(posedge clk); #1;   // output handshake (out_ready is 1)
   endtask

   task automatic run128(input logic [63:0] pt, input logic [127:0] key,
                         output logic [63:0] ct, output int lat);
      int guard;
      guard = 0;
      while (!b128.in_ready && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 200) check("run128_in_ready_timeout", 64'(guard), 64'd0);
      b128.plaintext = pt;
      b128.key       = key;
      b128.in_valid  = 1'b1;
      @(posedge clk); #1;
      b128.in_valid  = 1'b0;
      lat = 0;
      while (!b128.out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      ct = b128.ciphertext;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] ct;
      int          lat;
      int          stale;

      vecs[0] = '{64'h0,                  80'h0,                     64'h5579C1387B228445};
      vecs[1] = '{64'h0,                  80'hFFFF_FFFFFFFF_FFFFFFFF, 64'hE72C46C0F5945049};
      vecs[2] = '{64'hFFFFFFFF_FFFFFFFF,  80'h0,                     64'hA112FFC72F68417B};
      vecs[3] = '{64'hFFFFFFFF_FFFFFFFF,  80'hFFFF_FFFFFFFF_FFFFFFFF, 64'h3333DCD3213210D2};

      b80.in_valid = 1'b0;  b80.plaintext = '0;  b80.key = '0;  b80.out_ready = 1'b1;
      b128.in_valid = 1'b0; b128.plaintext = '0; b128.key = '0; b128.out_ready = 1'b1;
`ifdef PRESENT_DECRYPT_EN
      b80.dec = 1'b0;
      b128.dec = 1'b0;
`endif

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",   64'(b80.in_ready),  64'd0);
      check("rst_out_valid",  64'(b80.out_valid), 64'd0);
      check("rst_ciphertext", b80.ciphertext,     64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_in_ready", 64'(b80.in_ready), 64'd1);

      // Published 80-bit vectors and latency.
      for (int i = 0; i < 4; i++) begin
         run80(vecs[i].pt, vecs[i].key, 1'b0, ct, lat);
         check($sformatf("vec80_%0d_ct", i), ct, vecs[i].exp);
         check($sformatf("vec80_%0d_lat", i), 64'(lat), 64'd31);
      end

      // 128-bit key.
      run128(64'h0, 128'h0, ct, lat);
      check("vec128_ct",  ct, 64'h96DB702A2E6900AF);
      check("vec128_lat", 64'(lat), 64'd31);

      // Backpressure: result must hold, second request waits for the handshake.
      b80.out_ready = 1'b0;
      b80.plaintext = 64'h0;
      b80.key       = 80'hFFFF_FFFFFFFF_FFFFFFFF;
      b80.in_valid  = 1'b1;
      @(posedge clk); #1;
      b80.plaintext = 64'hFFFFFFFF_FFFFFFFF;   // pending request, must not be captured mid-run
      b80.key       = 80'h0;
      lat = 0;
      while (!b80.out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      check("bp_first_ct", b80.ciphertext, 64'hE72C46C0F5945049);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold_valid_%0d", c), 64'(b80.out_valid), 64'd1);
         check($sformatf("bp_hold_ct_%0d", c),    b80.ciphertext,     64'hE72C46C0F5945049);
         check($sformatf("bp_hold_ready_%0d", c), 64'(b80.in_ready),  64'd0);
      end
      b80.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_hs_valid_low", 64'(b80.out_valid), 64'd0);
      check("bp_hs_ready_high", 64'(b80.in_ready), 64'd1);
      check("bp_ct_kept",       b80.ciphertext,     64'hE72C46C0F5945049);
      @(posedge clk); #1;
      b80.in_valid = 1'b0;
      check("bp_second_accepted", 64'(b80.in_ready), 64'd0);
      lat = 0;
      while (!b80.out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      check("bp_second_ct",  b80.ciphertext, 64'hA112FFC72F68417B);
      check("bp_second_lat", 64'(lat), 64'd31);
      @(posedge clk); #1;

      // Reset abort at round 15.
      b80.plaintext = 64'h0;
      b80.key       = 80'hFFFF_FFFFFFFF_FFFFFFFF;
      b80.in_valid  = 1'b1;
      @(posedge clk); #1;
      b80.in_valid  = 1'b0;
      repeat (14) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid",  64'(b80.out_valid), 64'd0);
      check("abort_in_ready",   64'(b80.in_ready),  64'd0);
      check("abort_ciphertext", b80.ciphertext,     64'd0);
      @(negedge clk); rst_n = 1'b1;
      stale = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (b80.out_valid) stale++;
      end
      check("abort_no_stale_valid", 64'(stale), 64'd0);
      run80(vecs[0].pt, vecs[0].key, 1'b0, ct, lat);
      check("abort_rerun_ct",  ct, 64'h5579C1387B228445);
      check("abort_rerun_lat", 64'(lat), 64'd31);

`ifdef PRESENT_DECRYPT_EN
      run80(64'h5579C1387B228445, 80'h0, 1'b1, ct, lat);
      check("dec80_pt",  ct, 64'h0);
      check("dec80_lat", 64'(lat), 64'd63);
      run80(64'h0, 80'h0, 1'b0, ct, lat);
      check("enc_after_dec_ct",  ct, 64'h5579C1387B228445);
      check("enc_after_dec_lat", 64'(lat), 64'd31);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
